ring_pattern_gen: RTL and testbench
===================================

RING_PATTERN_GEN -- requirements
Module: ring_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0, asserted sync level (0 = active-low).
REQ-006 SHALL have parameters CX/CY, defaults 320/240, pattern centre in pixels.
REQ-007 SHALL have parameter COLOR_BITS, default 2, range 1..4, bits per colour channel.
REQ-008 clk  in  1  pixel clock; the block's only clock.
REQ-009 rst_n  in  1  reset, asynchronous and active-low.
REQ-010 cfg_mode  in  2  pattern: 0 rings, 1 diamond, 2 squares, 3 bars.
REQ-011 cfg_speed  in  2  phase step per frame = 1 << cfg_speed.
REQ-012 cfg_dir  in  1  0 = pattern moves outward, 1 = inward.
REQ-013 cfg_pause  in  1  1 = freeze the animation phase.
REQ-014 hsync, vsync  out  1  sync outputs, polarity per SYNC_POL.
REQ-015 display_on  out  1  high during the visible area.
REQ-016 red, green, blue  out  COLOR_BITS  pixel colour.
REQ-017 frame_start  out  1  one-clock pulse at the first pixel of each frame.
REQ-018 phase  out  8  current animation phase.

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- hpos counts 0..H_TOTAL-1 and wraps to 0.
- vpos increments when hpos wraps and itself wraps to 0 after V_TOTAL-1.
REQ-020 hsync SHALL be asserted for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC; vsync likewise on vpos.
REQ-021 display_on = (hpos < H_ACTIVE) && (vpos < V_ACTIVE).
REQ-022 Output pipeline: all outputs registered, one-clock latency from counter state.
- hsync, vsync, display_on and colour for pixel (h,v) SHALL appear together on the same clock.
REQ-023 frame_start SHALL pulse high for exactly one clock, aligned with the outputs of pixel (0,0).
REQ-024 Config shadowing: cfg_mode, cfg_speed, cfg_dir and cfg_pause SHALL be sampled only when counters = (0,0).
- Mid-frame changes SHALL have no visible effect until the next frame.
REQ-025 Phase update at counters = (0,0):
- cfg_pause=0: phase += 1<<cfg_speed, modulo 256 (255+1 wraps to 0).
- cfg_pause=1: phase holds.
- The new phase applies from pixel (0,0) of the same frame.
REQ-026 Distance metric: ax = |hpos-CX|, ay = |vpos-CY|, computed in 11-bit signed arithmetic.
- Mode 0: d = max(ax,ay) + (min(ax,ay)>>1).
- Mode 1: d = ax+ay.
- Mode 2: d = max(ax,ay).
- Mode 3: d = ax.
- d SHALL be truncated to its low 8 bits.
REQ-027 a = dir ? (d - phase) : (d + phase), modulo 256.
- red = a[4 +: COLOR_BITS], green = a[5 +: COLOR_BITS], blue = a[6 +: COLOR_BITS].
- Bits above a[7] read as 0.
REQ-028 red, green and blue SHALL be 0 whenever display_on would be 0 for that pixel.

Reset
REQ-029 While rst_n=0:
- hpos, vpos, phase and all shadow config registers = 0.
- red, green, blue, display_on and frame_start = 0.
- hsync and vsync = deasserted level (~SYNC_POL).
REQ-030 Reset assertion SHALL take effect immediately, without a clock edge.
- Asserting reset mid-frame SHALL abort the frame.
- After release, counting SHALL restart at (0,0); the first clock edge processes pixel (0,0), including its phase update and frame_start.

Verification
REQ-031 Defaults, reset released, run 2 frames.
- Expect 800 clocks per line and 525 lines per frame.
- Expect hsync low for 96 clocks starting at hpos 656, and vsync low for lines 490-491.
REQ-032 cfg_speed=2, cfg_pause=0, held for 3 frame starts.
- Expect phase 4, 8, 12.
- Preload phase 252 and pulse one frame: expect phase 0.
REQ-033 Mode 0, cfg_dir=0, phase=0.
- Pixel (320,240): colour 0.
- Pixel (336,240): d=16, red=1, green=0, blue=0.
- Pixel (400,260): d=90; red=1, green=2, blue=1.
REQ-034 Set cfg_mode=3 at pixel (100,200) mid-frame.
- Remaining pixels of that frame still show mode 0.
- Mode 3 appears from (0,0) of the next frame.
REQ-035 Assert rst_n=0 at pixel (500,300).
- Outputs go to reset values with no clock edge.
- After release: display_on=1 and frame_start=1 one clock later; phase = 1<<cfg_speed.
REQ-036 Sweep SYNC_POL=1 and COLOR_BITS=3 at any pixel in blanking.
- Expect sync high during the sync window and 3-bit channels.
- Expect colour 0 in all blanking regions.

Source files
------------

// File: rtl/ring_pattern_gen.sv
// Animated test-pattern generator with VGA-style timing.
// A raster counter drives registered sync/blank outputs. Colour comes from a
// distance-from-centre metric offset by a per-frame animation phase.
// Configuration inputs are captured only at the first pixel of each frame,
// so the pattern never tears mid-frame.
module ring_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_POL   = 0,
   parameter int CX         = 320,
   parameter int CY         = 240,
   parameter int COLOR_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            cfg_mode,
   input  logic [1:0]            cfg_speed,
   input  logic                  cfg_dir,
   input  logic                  cfg_pause,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  display_on,
   output logic [COLOR_BITS-1:0] red,
   output logic [COLOR_BITS-1:0] green,
   output logic [COLOR_BITS-1:0] blue,
   output logic                  frame_start,
   output logic [7:0]            phase
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          SYNC_ON  = (SYNC_POL != 0);

   logic [HW-1:0] hpos;
   logic [VW-1:0] vpos;
   logic          at_origin;

   // Only mode and direction need shadowing: speed and pause are consumed
   // solely at the frame origin, which is exactly when they are sampled.
   logic [1:0]    mode_q;
   logic          dir_q;

   logic [1:0]    mode_eff;
   logic          dir_eff;
   logic [7:0]    phase_next;
   logic [10:0]   dx, dy, ax, ay, mx, mn, sum;
   logic [7:0]    d, a;
   logic [11:0]   a_ext;
   logic          de, hs_act, vs_act;

   assign at_origin = (hpos == '0) && (vpos == '0);

   // Raster position: hpos wraps each line, vpos advances on hpos wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hpos <= '0;
         vpos <= '0;
      end else if (hpos == H_LAST) begin
         hpos <= '0;
         vpos <= (vpos == V_LAST) ? '0 : vpos + 1'b1;
      end else begin
         hpos <= hpos + 1'b1;
      end
   end

   // Capture config and advance the phase once per frame at the origin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= '0;
         dir_q  <= 1'b0;
         phase  <= '0;
      end else if (at_origin) begin
         mode_q <= cfg_mode;
         dir_q  <= cfg_dir;
         phase  <= phase_next;
      end
   end

   // Pixel (0,0) must already see the freshly captured config and phase.
   always_comb begin
      mode_eff   = at_origin ? cfg_mode : mode_q;
      dir_eff    = at_origin ? cfg_dir  : dir_q;
      phase_next = phase;
      if (at_origin && !cfg_pause)
         phase_next = phase + (8'd1 << cfg_speed);
   end

   // Distance from the pattern centre, then phase offset into colour bits.
   always_comb begin
      dx  = 11'(hpos) - 11'(CX);
      dy  = 11'(vpos) - 11'(CY);
      ax  = dx[10] ? (~dx + 11'd1) : dx;
      ay  = dy[10] ? (~dy + 11'd1) : dy;
      mx  = (ax > ay) ? ax : ay;
      mn  = (ax > ay) ? ay : ax;
      sum = '0;
      case (mode_eff)
         2'd0:    sum = mx + (mn >> 1);
         2'd1:    sum = ax + ay;
         2'd2:    sum = mx;
         default: sum = ax;
      endcase
      d     = sum[7:0];
      a     = dir_eff ? (d - phase_next) : (d + phase_next);
      a_ext = {4'b0000, a};
   end

   // Timing decode for the pixel currently addressed by the counters.
   always_comb begin
      de     = (hpos < H_ACT) && (vpos < V_ACT);
      hs_act = (hpos >= HS_BEGIN) && (hpos < HS_END);
      vs_act = (vpos >= VS_BEGIN) && (vpos < VS_END);
   end

   // Output register stage: everything for one pixel leaves together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= ~SYNC_ON;
         vsync       <= ~SYNC_ON;
         display_on  <= 1'b0;
         frame_start <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
      end else begin
         hsync       <= hs_act ? SYNC_ON : ~SYNC_ON;
         vsync       <= vs_act ? SYNC_ON : ~SYNC_ON;
         display_on  <= de;
         frame_start <= at_origin;
         red         <= de ? a_ext[4 +: COLOR_BITS] : '0;
         green       <= de ? a_ext[5 +: COLOR_BITS] : '0;
         blue        <= de ? a_ext[6 +: COLOR_BITS] : '0;
      end
   end

endmodule

// File: tb/tb_ring_pattern_gen.sv
// Bench for ring_pattern_gen: two shrunken-timing instances checked every
// clock against a behavioural model, plus a default-parameter instance
// checked for line timing, hand-computed pixel tables and corner sequences.
module tb_ring_pattern_gen;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, sp, cx, cy, cb;
   } prm_t;

   typedef struct {
      int h, v, phase, mode, dir;
   } mst_t;

   typedef struct packed {
      logic       hs, vs, de, fs;
      logic [3:0] r, g, b;
      logic [7:0] ph;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      logic       dir;
      int         h, v;
      logic       de;
      logic [1:0] r, g, b;
   } vec_t;

   prm_t pa = '{64, 2, 4, 2, 40, 1, 2, 1, 0, 20, 10, 2};
   prm_t pb = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 4, 2, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int out_h[2];
   int out_v[2];

   // instance A: small timing, SYNC_POL 0, 2-bit colour
   logic       rst_a = 1'b0;
   logic [1:0] cfg_mode_a = 2'd0, cfg_speed_a = 2'd3;
   logic       cfg_dir_a = 1'b0, cfg_pause_a = 1'b0;
   logic       hsync_a, vsync_a, display_on_a, frame_start_a;
   logic [1:0] red_a, green_a, blue_a;
   logic [7:0] phase_a;

   // instance B: tiny timing, SYNC_POL 1, 3-bit colour
   logic       rst_b = 1'b0;
   logic [1:0] cfg_mode_b = 2'd1, cfg_speed_b = 2'd2;
   logic       cfg_dir_b = 1'b1, cfg_pause_b = 1'b0;
   logic       hsync_b, vsync_b, display_on_b, frame_start_b;
   logic [2:0] red_b, green_b, blue_b;
   logic [7:0] phase_b;

   // instance C: default parameters
   logic       rst_c = 1'b0;
   logic [1:0] cfg_mode_c = 2'd0, cfg_speed_c = 2'd0;
   logic       cfg_dir_c = 1'b0, cfg_pause_c = 1'b0;
   logic       hsync_c, vsync_c, display_on_c, frame_start_c;
   logic [1:0] red_c, green_c, blue_c;
   logic [7:0] phase_c;

   ring_pattern_gen #(
      .H_ACTIVE(64), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(0), .CX(20), .CY(10), .COLOR_BITS(2)
   ) dut_a (
      .clk(clk), .rst_n(rst_a), .cfg_mode(cfg_mode_a), .cfg_speed(cfg_speed_a),
      .cfg_dir(cfg_dir_a), .cfg_pause(cfg_pause_a), .hsync(hsync_a), .vsync(vsync_a),
      .display_on(display_on_a), .red(red_a), .green(green_a), .blue(blue_a),
      .frame_start(frame_start_a), .phase(phase_a)
   );

   ring_pattern_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1), .CX(4), .CY(2), .COLOR_BITS(3)
   ) dut_b (
      .clk(clk), .rst_n(rst_b), .cfg_mode(cfg_mode_b), .cfg_speed(cfg_speed_b),
      .cfg_dir(cfg_dir_b), .cfg_pause(cfg_pause_b), .hsync(hsync_b), .vsync(vsync_b),
      .display_on(display_on_b), .red(red_b), .green(green_b), .blue(blue_b),
      .frame_start(frame_start_b), .phase(phase_b)
   );

   ring_pattern_gen dut_c (
      .clk(clk), .rst_n(rst_c), .cfg_mode(cfg_mode_c), .cfg_speed(cfg_speed_c),
      .cfg_dir(cfg_dir_c), .cfg_pause(cfg_pause_c), .hsync(hsync_c), .vsync(vsync_c),
      .display_on(display_on_c), .red(red_c), .green(green_c), .blue(blue_c),
      .frame_start(frame_start_c), .phase(phase_c)
   );

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
      n_cmp++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp_v, $time);
      end
   endtask

   function automatic exp_t rst_exp(input prm_t p);
      exp_t e;
      e    = '0;
      e.hs = (p.sp == 0);
      e.vs = (p.sp == 0);
      return e;
   endfunction

   function automatic exp_t pack_a();
      exp_t e;
      e = '{hsync_a, vsync_a, display_on_a, frame_start_a,
            4'(red_a), 4'(green_a), 4'(blue_a), phase_a};
      return e;
   endfunction

   function automatic exp_t pack_b();
      exp_t e;
      e = '{hsync_b, vsync_b, display_on_b, frame_start_b,
            4'(red_b), 4'(green_b), 4'(blue_b), phase_b};
      return e;
   endfunction

   // Behavioural reference: outputs for pixel si.(h,v) and the next state.
   task automatic model_step(input prm_t p, input mst_t si, input logic [1:0] m, sp,
                             input logic dr, pz, output mst_t so, output exp_t e);
      int  ax, ay, mx, mn, dd, a, msk, ht, vt;
      logic act;
      so = si;
      if (si.h == 0 && si.v == 0) begin
         so.mode = int'(m);
         so.dir  = int'(dr);
         if (!pz) so.phase = (si.phase + (1 << sp)) % 256;
      end
      ax = si.h - p.cx; if (ax < 0) ax = -ax;
      ay = si.v - p.cy; if (ay < 0) ay = -ay;
      mx = (ax > ay) ? ax : ay;
      mn = (ax > ay) ? ay : ax;
      case (so.mode)
         0:       dd = mx + mn / 2;
         1:       dd = ax + ay;
         2:       dd = mx;
         default: dd = ax;
      endcase
      dd  = dd % 256;
      a   = (so.dir != 0) ? (dd - so.phase) : (dd + so.phase);
      a   = a & 255;
      act = (si.h < p.ha) && (si.v < p.va);
      msk = (1 << p.cb) - 1;
      e.hs = (si.h >= p.ha + p.hf && si.h < p.ha + p.hf + p.hs) ? (p.sp != 0) : (p.sp == 0);
      e.vs = (si.v >= p.va + p.vf && si.v < p.va + p.vf + p.vs) ? (p.sp != 0) : (p.sp == 0);
      e.de = act;
      e.fs = (si.h == 0 && si.v == 0);
      e.r  = act ? 4'((a >> 4) & msk) : 4'd0;
      e.g  = act ? 4'((a >> 5) & msk) : 4'd0;
      e.b  = act ? 4'((a >> 6) & msk) : 4'd0;
      e.ph = 8'(so.phase);
      ht = p.ha + p.hf + p.hs + p.hb;
      vt = p.va + p.vf + p.vs + p.vb;
      so.h = si.h + 1;
      if (so.h == ht) begin
         so.h = 0;
         so.v = (si.v + 1 == vt) ? 0 : si.v + 1;
      end
   endtask

   exp_t qa[$];
   exp_t qb[$];

   // scoreboard producers: model each processed pixel at the clock edge
   initial begin
      mst_t s, sn;
      exp_t e;
      s = '{default: 0};
      forever begin
         @(posedge clk);
         if (!rst_a) begin
            s = '{default: 0};
            out_h[0] = -1; out_v[0] = -1;
         end else begin
            model_step(pa, s, cfg_mode_a, cfg_speed_a, cfg_dir_a, cfg_pause_a, sn, e);
            qa.push_back(e);
            out_h[0] = s.h; out_v[0] = s.v;
            s = sn;
         end
      end
   end

   initial begin
      mst_t s, sn;
      exp_t e;
      s = '{default: 0};
      forever begin
         @(posedge clk);
         if (!rst_b) begin
            s = '{default: 0};
            out_h[1] = -1; out_v[1] = -1;
         end else begin
            model_step(pb, s, cfg_mode_b, cfg_speed_b, cfg_dir_b, cfg_pause_b, sn, e);
            qb.push_back(e);
            out_h[1] = s.h; out_v[1] = s.v;
            s = sn;
         end
      end
   end

   // scoreboard consumers: compare on the falling edge
   initial forever begin
      @(negedge clk);
      if (!rst_a) begin
         qa.delete();
         check("sb_a_reset", pack_a(), rst_exp(pa));
      end else if (qa.size() > 0) begin
         check("sb_a", pack_a(), qa.pop_front());
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst_b) begin
         qb.delete();
         check("sb_b_reset", pack_b(), rst_exp(pb));
      end else if (qb.size() > 0) begin
         check("sb_b", pack_b(), qb.pop_front());
      end
   end

   task automatic wait_pix(input int which, input int h, input int v);
      int n;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!(out_h[which] == h && out_v[which] == v) && n < 5000);
      if (!(out_h[which] == h && out_v[which] == v)) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_pix%0d: pixel (%0d,%0d) not reached, at (%0d,%0d)",
                  which, h, v, out_h[which], out_v[which]);
      end
   endtask

   task automatic run_a();
      vec_t tbl[10];
      tbl[0] = '{2'd0, 1'b0, 20, 10, 1'b1, 2'd0, 2'd0, 2'd0};
      tbl[1] = '{2'd0, 1'b1, 20, 10, 1'b1, 2'd3, 2'd3, 2'd3};
      tbl[2] = '{2'd0, 1'b0, 60, 30, 1'b1, 2'd3, 2'd1, 2'd0};
      tbl[3] = '{2'd1, 1'b0, 60, 30, 1'b1, 2'd0, 2'd2, 2'd1};
      tbl[4] = '{2'd2, 1'b1,  5, 35, 1'b1, 2'd1, 2'd0, 2'd0};
      tbl[5] = '{2'd3, 1'b0, 63,  0, 1'b1, 2'd3, 2'd1, 2'd0};
      tbl[6] = '{2'd1, 1'b1,  0,  0, 1'b1, 2'd1, 2'd0, 2'd0};
      tbl[7] = '{2'd2, 1'b0, 70,  5, 1'b0, 2'd0, 2'd0, 2'd0};
      tbl[8] = '{2'd0, 1'b0, 27, 15, 1'b1, 2'd1, 2'd0, 2'd0};
      tbl[9] = '{2'd0, 1'b0,  0, 39, 1'b1, 2'd2, 2'd1, 2'd0};

      repeat (3) @(negedge clk);
      #1;
      check("a_reset_state", pack_a(), rst_exp(pa));
      rst_a = 1'b1;
      wait_pix(0, 0, 0);
      check("a_first_frame", {display_on_a, frame_start_a, phase_a}, {1'b1, 1'b1, 8'd8});
      cfg_pause_a = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cfg_mode_a = tbl[i].mode;
         cfg_dir_a  = tbl[i].dir;
         wait_pix(0, 0, 0);
         if (!(tbl[i].h == 0 && tbl[i].v == 0)) wait_pix(0, tbl[i].h, tbl[i].v);
         check($sformatf("tbl%0d", i), {display_on_a, red_a, green_a, blue_a},
               {tbl[i].de, tbl[i].r, tbl[i].g, tbl[i].b});
      end

      // mid-frame mode change must wait for the next frame
      cfg_mode_a = 2'd0;
      cfg_dir_a  = 1'b0;
      wait_pix(0, 0, 0);
      wait_pix(0, 30, 20);
      cfg_mode_a = 2'd3;
      wait_pix(0, 40, 25);
      check("a_midframe_old", {red_a, green_a, blue_a}, {2'd2, 2'd1, 2'd0});
      wait_pix(0, 0, 0);
      wait_pix(0, 40, 25);
      check("a_midframe_new", {red_a, green_a, blue_a}, {2'd1, 2'd0, 2'd0});

      // asynchronous reset mid-frame, then restart at the origin
      wait_pix(0, 50, 30);
      rst_a = 1'b0;
      #1;
      check("a_async_reset", pack_a(), rst_exp(pa));
      cfg_pause_a = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst_a = 1'b1;
      @(negedge clk); #1;
      check("a_restart", {display_on_a, frame_start_a, phase_a}, {1'b1, 1'b1, 8'd8});
      cfg_speed_a = 2'd1;
      wait_pix(0, 0, 0);
      check("a_speed1", phase_a, 8'd10);
   endtask

   task automatic run_b();
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst_b = 1'b1;
      for (int k = 1; k <= 63; k++) begin
         wait_pix(1, 0, 0);
         if (k <= 3) check($sformatf("b_phase_step%0d", k), phase_b, 32'(4 * k));
         if (k == 1) begin
            wait_pix(1, 4, 2);
            check("b_colour3", {red_b, green_b, blue_b}, {3'd7, 3'd7, 3'd3});
         end
      end
      check("b_phase_252", phase_b, 8'd252);
      wait_pix(1, 0, 0);
      check("b_phase_wrap", phase_b, 8'd0);
      cfg_pause_b = 1'b1;
      wait_pix(1, 0, 0);
      check("b_pause_hold", phase_b, 8'd0);
      wait_pix(1, 10, 1);
      check("b_hsync_on", {hsync_b, red_b, green_b, blue_b}, 10'b1_000_000_000);
      wait_pix(1, 12, 1);
      check("b_hsync_off", {hsync_b, red_b, green_b, blue_b}, 10'b0_000_000_000);
      wait_pix(1, 3, 5);
      check("b_vsync_on", {vsync_b, display_on_b, red_b, green_b, blue_b}, 11'b10_000_000_000);
   endtask

   task automatic run_c();
      int de_fall, de_rise2, hs_first, hs_second, hs_len, fs_count;
      logic de_prev, hs_prev;
      de_fall = -1; de_rise2 = -1; hs_first = -1; hs_second = -1;
      hs_len = 0; fs_count = 0; de_prev = 1'b0; hs_prev = 1'b1;
      @(negedge clk); #1;
      rst_c = 1'b1;
      for (int n = 1; n <= 1700; n++) begin
         @(negedge clk);
         if (frame_start_c) fs_count++;
         if (de_prev && !display_on_c && de_fall < 0) de_fall = n;
         if (!de_prev && display_on_c && n > 1 && de_rise2 < 0) de_rise2 = n;
         if (hs_prev && !hsync_c) begin
            if (hs_first < 0) hs_first = n;
            else if (hs_second < 0) hs_second = n;
         end
         if (!hsync_c && hs_second < 0) hs_len++;
         de_prev = display_on_c;
         hs_prev = hsync_c;
      end
      check("c_de_fall", de_fall, 641);
      check("c_line_len", de_rise2, 801);
      check("c_hsync_start", hs_first, 657);
      check("c_hsync_width", hs_len, 96);
      check("c_hsync_period", hs_second, 1457);
      check("c_frame_start_cnt", fs_count, 1);
   endtask

   initial begin
      fork
         run_a();
         run_b();
         run_c();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
